// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
//   state_e : controller state encoding (IDLE, RUN, DONE)
//   cnt_w() : bit counter width for a given operand width, $clog2(WIDTH+1)
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a requester and serial_add_ctrl.
// Optional macro: SERIAL_ADD_SUB_EN adds the SUB request bit.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready. The sender keeps valid and its payload stable until
// that edge; ready may depend on state but never on the same-cycle valid.
//   request : start_valid / start_ready, payload A, B, Cin (and SUB)
//   response: done_valid / done_ready, payload S, Cout
//   busy    : controller is in RUN or DONE
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             SUB;
`endif
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  modport master (
    output start_valid, A, B, Cin,
`ifdef SERIAL_ADD_SUB_EN
    output SUB,
`endif
    output done_ready,
    input  start_ready, S, Cout, done_valid, busy
  );

  modport slave (
    input  start_valid, A, B, Cin,
`ifdef SERIAL_ADD_SUB_EN
    input  SUB,
`endif
    input  done_ready,
    output start_ready, S, Cout, done_valid, busy
  );
endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// Single 1-bit full adder cell shared by the serial sequencer.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full_adder is reused over WIDTH cycles,
// LSB first, to produce {Cout,S} = A + B + Cin.
// Optional macro: SERIAL_ADD_SUB_EN adds a SUB request bit (S = A - B,
// Cout=1 meaning no borrow).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : serial_add_ctrl_if slave (request, response, busy)
//   dbg_state  : current controller state
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_add_ctrl_if.slave   bus,
  output state_e             dbg_state
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WIDTH-1:0]   a_sh_q,     a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,     b_sh_d;
  logic               carry_q,    carry_d;
  logic [WIDTH-1:0]   sum_sh_q,   sum_sh_d;
  logic [WIDTH-1:0]   s_q,        s_d;
  logic               cout_q,     cout_d;
  logic               done_valid_q, done_valid_d;
  logic               sub_bit;

  logic fa_b;
  logic fa_s;
  logic fa_cout;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;
  assign sub_bit = sub_q;
`else
  assign sub_bit = 1'b0;
`endif

  // Subtraction is A + ~B + 1: invert B on its way into the cell.
  assign fa_b = b_sh_q[0] ^ sub_bit;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (fa_b),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    carry_d      = carry_q;
    sum_sh_d     = sum_sh_q;
    s_d          = s_q;
    cout_d       = cout_q;
    done_valid_d = done_valid_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d        = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          state_d  = RUN;
          a_sh_d   = bus.A;
          b_sh_d   = bus.B;
          carry_d  = bus.Cin;
          cnt_d    = '0;
          sum_sh_d = '0;
`ifdef SERIAL_ADD_SUB_EN
          sub_d    = bus.SUB;
          if (bus.SUB) carry_d = 1'b1;
`endif
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_cout;
        // New sum bit enters at the MSB; after WIDTH steps the first
        // (LSB) sum bit has travelled down to bit 0.
        sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d      = DONE;
          s_d          = sum_sh_d;
          cout_d       = fa_cout;
          done_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (bus.done_ready) begin
          state_d      = IDLE;
          done_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      carry_q      <= 1'b0;
      sum_sh_q     <= '0;
      s_q          <= '0;
      cout_q       <= 1'b0;
      done_valid_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      carry_q      <= carry_d;
      sum_sh_q     <= sum_sh_d;
      s_q          <= s_d;
      cout_q       <= cout_d;
      done_valid_q <= done_valid_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q        <= sub_d;
`endif
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.S           = s_q;
  assign bus.Cout        = cout_q;
  assign bus.done_valid  = done_valid_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8). Honors SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int WIDTH = 8;
`ifdef SERIAL_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();
  state_e dbg_state;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [WIDTH:0] exp_q[$];   // expected {Cout,S} per accepted request
  int             lat_q[$];   // cycle index at which done_valid must rise
  int checks = 0;
  int errors = 0;
  int dr_mode = 2;            // 0 random, 1 hold low, 2 always high

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, subtraction as A + (2^W-1-B) + 1.
  function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin, input logic sub);
    logic [WIDTH:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub);
    int waited = 0;
    logic eff_sub;
    eff_sub = SUB_EN ? sub : 1'b0;
    bus.A = a;
    bus.B = b;
    bus.Cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.SUB = sub;
`endif
    bus.start_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.start_ready) break;
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 64'(waited), 64'd0);
        bus.start_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(ref_result(a, b, cin, eff_sub));
    lat_q.push_back(cyc + 1 + WIDTH);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    // Scramble operands after the handshake; they must not matter.
    bus.A = WIDTH'($urandom);
    bus.B = WIDTH'($urandom);
    bus.Cin = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SUB_EN
    bus.SUB = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- consumer ----------------
  always @(posedge clk) begin
    #1;
    case (dr_mode)
      0:       bus.done_ready = 1'($urandom_range(0, 1));
      1:       bus.done_ready = 1'b0;
      default: bus.done_ready = 1'b1;
    endcase
  end

  // ---------------- monitor ----------------
  logic           prev_dv = 1'b0;
  logic           prev_dr = 1'b0;
  logic [WIDTH:0] prev_res = '0;
  logic           exp_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dv  = 1'b0;
      prev_dr  = 1'b0;
      exp_busy = 1'b0;
    end else begin
      check("start_ready", 64'(bus.start_ready), 64'(!exp_busy));
      check("busy", 64'(bus.busy), 64'(exp_busy));
      if (bus.done_valid && !prev_dv) begin
        if (lat_q.size() == 0) check("unexpected_done", 64'(cyc), 64'd0);
        else check("latency", 64'(cyc), 64'(lat_q.pop_front()));
      end
      if (prev_dv && !prev_dr) begin
        check("hold_valid", 64'(bus.done_valid), 64'd1);
        check("hold_result", 64'({bus.Cout, bus.S}), 64'(prev_res));
      end
      if (prev_dv && prev_dr) begin
        check("drop_valid", 64'(bus.done_valid), 64'd0);
        check("keep_result", 64'({bus.Cout, bus.S}), 64'(prev_res));
      end
      if (bus.done_valid && bus.done_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 64'({bus.Cout, bus.S}), 64'd0);
        else check("result", 64'({bus.Cout, bus.S}), 64'(exp_q.pop_front()));
      end
      // Higher-level busy model: busy from accept edge until response edge.
      if (bus.start_valid && !exp_busy) exp_busy = 1'b1;
      if (bus.done_valid && bus.done_ready) exp_busy = 1'b0;
      prev_dv  = bus.done_valid;
      prev_dr  = bus.done_ready;
      prev_res = {bus.Cout, bus.S};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.start_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
    bus.done_ready = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus.SUB = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_S", 64'(bus.S), 64'd0);
    check("rst_Cout", 64'(bus.Cout), 64'd0);
    check("rst_done_valid", 64'(bus.done_valid), 64'd0);
    @(posedge clk);
    #1;

    // Directed vectors
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    send(8'h5A, 8'h33, 1'b1, 1'b0);
    send(8'h00, 8'h00, 1'b0, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    if (SUB_EN) begin
      send(8'h10, 8'h01, 1'b0, 1'b1);
      send(8'h01, 8'h02, 1'b1, 1'b1);
    end
    wait_drain();

    // Backpressure: consumer stalls, a second request waits with valid high
    dr_mode = 1;
    fork
      begin
        send(8'h12, 8'h34, 1'b0, 1'b0);
        send(8'h80, 8'h80, 1'b1, 1'b0);
      end
      begin
        repeat (WIDTH + 7) @(posedge clk);
        #2 dr_mode = 2;
      end
    join
    wait_drain();

    // Reset in the middle of RUN abandons the operation
    send(8'hC3, 8'h3C, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    check("midrst_S", 64'(bus.S), 64'd0);
    check("midrst_Cout", 64'(bus.Cout), 64'd0);
    check("midrst_done_valid", 64'(bus.done_valid), 64'd0);
    repeat (WIDTH + 3) @(posedge clk);
    #1;
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_drain();

    // Randomized traffic with random backpressure
    dr_mode = 0;
    repeat (40) begin
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #0;
    end
    dr_mode = 2;
    wait_drain();

    check("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
